tt_um_saanvi_count_checker: RTL and testbench



---
 rtl/tt_um_saanvi_count_checker.sv | 132 +++++++++++++
 tb/tb_tt_um_saanvi_count_checker.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tt_um_saanvi_count_checker.sv
// Receive-side count-stream checker: verifies each valid sample is the previous sample plus one (mod 256),
// and tracks lock/lost state, a saturating error count and the last sample seen.
module tt_um_saanvi_count_checker #(
  parameter int ERR_LIMIT    = 4,
  parameter int RELOCK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_LOST   = 2'd2
  } state_t;

  localparam logic [4:0] ERR_LIM    = 5'(ERR_LIMIT);
  localparam logic [4:0] RELOCK_LIM = 5'(RELOCK_COUNT);

  state_t     state_q, state_d;
  logic [7:0] expected_q, expected_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] last_q, last_d;
  logic [3:0] miss_run_q, miss_run_d;
  logic [3:0] good_run_q, good_run_d;
  logic       err_pulse_q, err_pulse_d;
  logic       sample_seen_q, sample_seen_d;

  logic       valid_in, clear_in, out_sel_in;
  logic       match;
  logic [4:0] miss_run_inc, good_run_inc;

  assign valid_in     = uio_in[0];
  assign clear_in     = uio_in[1];
  assign out_sel_in   = uio_in[2];
  assign match        = (ui_in == expected_q);
  assign miss_run_inc = {1'b0, miss_run_q} + 5'd1;
  assign good_run_inc = {1'b0, good_run_q} + 5'd1;

  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    err_cnt_d     = err_cnt_q;
    last_d        = last_q;
    miss_run_d    = miss_run_q;
    good_run_d    = good_run_q;
    err_pulse_d   = 1'b0;
    sample_seen_d = sample_seen_q;

    if (ena) begin
      // clear wins over a same-edge sample; last is deliberately kept
      if (clear_in) begin
        state_d       = ST_IDLE;
        err_cnt_d     = 8'd0;
        miss_run_d    = 4'd0;
        good_run_d    = 4'd0;
        sample_seen_d = 1'b0;
      end else if (valid_in) begin
        last_d        = ui_in;
        sample_seen_d = 1'b1;
        unique case (state_q)
          ST_IDLE: begin
            expected_d = ui_in + 8'd1;
            state_d    = ST_LOCKED;
          end
          ST_LOCKED: begin
            if (match) begin
              expected_d = expected_q + 8'd1;
              miss_run_d = 4'd0;
            end else begin
              if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
              err_pulse_d = 1'b1;
              expected_d  = ui_in + 8'd1;
              miss_run_d  = miss_run_inc[3:0];
              if (miss_run_inc == ERR_LIM) begin
                state_d    = ST_LOST;
                good_run_d = 4'd0;
              end
            end
          end
          ST_LOST: begin
            if (match) begin
              expected_d = expected_q + 8'd1;
              good_run_d = good_run_inc[3:0];
              if (good_run_inc == RELOCK_LIM) begin
                state_d    = ST_LOCKED;
                miss_run_d = 4'd0;
              end
            end else begin
              expected_d = ui_in + 8'd1;
              good_run_d = 4'd0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      expected_q    <= 8'd0;
      err_cnt_q     <= 8'd0;
      last_q        <= 8'd0;
      miss_run_q    <= 4'd0;
      good_run_q    <= 4'd0;
      err_pulse_q   <= 1'b0;
      sample_seen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      err_cnt_q     <= err_cnt_d;
      last_q        <= last_d;
      miss_run_q    <= miss_run_d;
      good_run_q    <= good_run_d;
      err_pulse_q   <= err_pulse_d;
      sample_seen_q <= sample_seen_d;
    end
  end

  assign uo_out  = out_sel_in ? last_q : err_cnt_q;
  assign uio_out = {sample_seen_q, err_pulse_q, (state_q == ST_LOST), (state_q == ST_LOCKED), 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_saanvi_count_checker.sv
// Directed bench for the count checker: linear stimulus with hand-computed expectations.
module tb_tt_um_saanvi_count_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic       valid = 1'b0, clr = 1'b0, sel = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_chk = 0;
  int n_fail = 0;

  assign uio_in = {5'b00000, sel, clr, valid};

  always #5 clk = ~clk;

  tt_um_saanvi_count_checker dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // uio_out status codes: 0x90 locked+seen, 0xD0 locked+pulse+seen, 0xA0 lost+seen, 0xE0 lost+pulse+seen
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] v, input logic vld, input logic c, input logic en);
    ui_in = v; valid = vld; clr = c; ena = en;
    @(posedge clk); #1;
  endtask

  task automatic chk_uo(input string tag, input logic s, input logic [7:0] exp);
    sel = s; #1;
    chk(tag, uo_out, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    step(8'd0, 1'b0, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_uio_out", uio_out, 8'h00);
    chk_uo("reset_err", 1'b0, 8'h00);
    chk_uo("reset_last", 1'b1, 8'h00);
    chk("uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;

    // first sample locks without being checked
    step(8'd10, 1'b1, 1'b0, 1'b1);
    chk("first_lock", uio_out, 8'h90);
    step(8'd11, 1'b1, 1'b0, 1'b1);
    step(8'd12, 1'b1, 1'b0, 1'b1);
    step(8'd13, 1'b1, 1'b0, 1'b1);
    chk("seq_status", uio_out, 8'h90);
    chk_uo("seq_err", 1'b0, 8'd0);
    chk_uo("seq_last", 1'b1, 8'd13);

    // wrap-around 251..255,0,1 after locking on 250
    step(8'd0, 1'b0, 1'b1, 1'b1);
    step(8'd250, 1'b1, 1'b0, 1'b1);
    for (int v = 251; v <= 257; v++) begin
      step(8'(v), 1'b1, 1'b0, 1'b1);
      chk("wrap_status", uio_out, 8'h90);
    end
    chk_uo("wrap_err", 1'b0, 8'd0);

    // single mismatch with resync: expected 20, send 20, 99, 100
    step(8'd0, 1'b0, 1'b1, 1'b1);
    step(8'd19, 1'b1, 1'b0, 1'b1);
    step(8'd20, 1'b1, 1'b0, 1'b1);
    step(8'd99, 1'b1, 1'b0, 1'b1);
    chk("resync_pulse", uio_out, 8'hD0);
    chk_uo("resync_err", 1'b0, 8'd1);
    step(8'd100, 1'b1, 1'b0, 1'b1);
    chk("resync_after", uio_out, 8'h90);
    chk_uo("resync_err2", 1'b0, 8'd1);
    step(8'd0, 1'b0, 1'b0, 1'b1);
    chk("gap_no_pulse", uio_out, 8'h90);

    // four consecutive mismatches force LOST; then relock after three matches
    step(8'd0, 1'b0, 1'b1, 1'b1);
    step(8'd1, 1'b1, 1'b0, 1'b1);
    step(8'd5, 1'b1, 1'b0, 1'b1);
    step(8'd9, 1'b1, 1'b0, 1'b1);
    step(8'd13, 1'b1, 1'b0, 1'b1);
    chk("three_miss_locked", uio_out, 8'hD0);
    step(8'd17, 1'b1, 1'b0, 1'b1);
    chk("enter_lost", uio_out, 8'hE0);
    chk_uo("lost_err", 1'b0, 8'd4);
    step(8'd40, 1'b1, 1'b0, 1'b1);
    chk("lost_mismatch", uio_out, 8'hA0);
    chk_uo("lost_err_hold", 1'b0, 8'd4);
    step(8'd41, 1'b1, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b1);
    chk("lost_gap", uio_out, 8'hA0);
    step(8'd42, 1'b1, 1'b0, 1'b1);
    chk("lost_two_good", uio_out, 8'hA0);
    step(8'd43, 1'b1, 1'b0, 1'b1);
    chk("relock", uio_out, 8'h90);
    chk_uo("relock_err", 1'b0, 8'd4);

    // drive err_cnt to 255 with mismatch/match pairs, then one more mismatch
    for (int i = 0; i < 251; i++) begin
      step(8'h80, 1'b1, 1'b0, 1'b1);
      step(8'h81, 1'b1, 1'b0, 1'b1);
    end
    chk_uo("err_255", 1'b0, 8'hFF);
    step(8'h80, 1'b1, 1'b0, 1'b1);
    chk("sat_pulse", uio_out, 8'hD0);
    chk_uo("sat_err", 1'b0, 8'hFF);

    // clear wins over same-edge sample; last retained
    step(8'd7, 1'b1, 1'b1, 1'b1);
    chk("clear_status", uio_out, 8'h00);
    chk_uo("clear_err", 1'b0, 8'd0);
    chk_uo("clear_last", 1'b1, 8'h80);
    step(8'd50, 1'b1, 1'b0, 1'b1);
    chk("relock_50", uio_out, 8'h90);
    step(8'd51, 1'b1, 1'b0, 1'b1);
    chk("match_51", uio_out, 8'h90);
    chk_uo("err_after_51", 1'b0, 8'd0);

    // ena=0 clears the pulse and takes no sample
    step(8'd200, 1'b1, 1'b0, 1'b1);
    chk("pulse_200", uio_out, 8'hD0);
    step(8'd77, 1'b1, 1'b0, 1'b0);
    chk("ena0_status", uio_out, 8'h90);
    chk_uo("ena0_last", 1'b1, 8'd200);
    chk_uo("ena0_err", 1'b0, 8'd1);

    // mid-stream reset with valid asserted
    rst_n = 1'b0;
    step(8'd201, 1'b1, 1'b0, 1'b1);
    chk("rst_status", uio_out, 8'h00);
    chk_uo("rst_err", 1'b0, 8'd0);
    chk_uo("rst_last", 1'b1, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
